// File: rtl/kp_pkg.sv
// Shared types, constants and helpers for the 4x4 keypad scan controller.
package kp_pkg;

    typedef enum logic [1:0] {
        SCAN,
        DEBOUNCE,
        EMIT,
        RELEASE
    } kp_state_t;

    localparam logic [3:0] KPR_IDLE  = 4'b1111;
    localparam logic [3:0] COL_RESET = 4'b0111;

    // Rotate right so the single low bit walks 0111 -> 1011 -> 1101 -> 1110 -> 0111.
    function automatic logic [3:0] next_col(input logic [3:0] col);
        return {col[0], col[3:1]};
    endfunction

    // {exactly-one-low, index of that low bit counted from the MSB}
    function automatic logic [2:0] low_index(input logic [3:0] v);
        logic [2:0] res;
        case (v)
            4'b0111: res = 3'b100;
            4'b1011: res = 3'b101;
            4'b1101: res = 3'b110;
            4'b1110: res = 3'b111;
            default: res = 3'b000;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/kp_keymap.sv
// Combinational map from (driven column, row pattern) to the 4-bit key code.
module kp_keymap
    import kp_pkg::*;
(
    input  logic [3:0] kpc,
    input  logic [3:0] pat,
    output logic [3:0] code,
    output logic       single
);

    logic [2:0] w_col;
    logic [2:0] w_row;

    assign w_col  = low_index(kpc);
    assign w_row  = low_index(pat);
    assign single = w_row[2];

    always_comb begin
        code = 4'd0;
        if (w_col[2] && w_row[2]) begin
            case ({w_col[1:0], w_row[1:0]})
                4'h0: code = 4'd1;
                4'h1: code = 4'd4;
                4'h2: code = 4'd7;
                4'h3: code = 4'd14;
                4'h4: code = 4'd2;
                4'h5: code = 4'd5;
                4'h6: code = 4'd8;
                4'h7: code = 4'd0;
                4'h8: code = 4'd3;
                4'h9: code = 4'd6;
                4'hA: code = 4'd9;
                4'hB: code = 4'd15;
                4'hC: code = 4'd10;
                4'hD: code = 4'd11;
                4'hE: code = 4'd12;
                4'hF: code = 4'd13;
            endcase
        end
    end

endmodule

// File: rtl/kp_scan_ctrl.sv
// 4x4 keypad scanner: column drive, row sync/debounce, one valid/ready event per press.
//
// state    | meaning
// SCAN     | drive each column SCAN_DIV cycles, look for any low row
// DEBOUNCE | column frozen, row pattern must hold DEB_CYCLES cycles
// EMIT     | event presented, waiting for key_ready
// RELEASE  | rows must read idle DEB_CYCLES cycles before scanning resumes
module kp_scan_ctrl
    import kp_pkg::*;
#(
    parameter int SCAN_DIV   = 50000,
    parameter int DEB_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] kpr,
    output logic [3:0] kpc,
    output logic       key_valid,
    output logic [3:0] key_code,
    input  logic       key_ready,
    output logic       key_down
);

    localparam int SW = $clog2(SCAN_DIV);
    localparam int DW = $clog2(DEB_CYCLES);
    localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
    localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CYCLES - 1);

    kp_state_t     r_state;
    logic [3:0]    r_sync1;
    logic [3:0]    r_kpr_s;
    logic [3:0]    r_kpc;
    logic [3:0]    r_pat;
    logic [SW-1:0] r_scan_cnt;
    logic [DW-1:0] r_deb_cnt;
    logic          r_key_valid;
    logic [3:0]    r_key_code;
    logic          r_key_down;

    logic [3:0]    w_code;
    logic          w_single;

    kp_keymap u_keymap (
        .kpc    (r_kpc),
        .pat    (r_pat),
        .code   (w_code),
        .single (w_single)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_sync1 <= KPR_IDLE;
            r_kpr_s <= KPR_IDLE;
        end else begin
            r_sync1 <= kpr;
            r_kpr_s <= r_sync1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state     <= SCAN;
            r_kpc       <= COL_RESET;
            r_pat       <= KPR_IDLE;
            r_scan_cnt  <= '0;
            r_deb_cnt   <= '0;
            r_key_valid <= 1'b0;
            r_key_code  <= 4'd0;
            r_key_down  <= 1'b0;
        end else begin
            case (r_state)
                SCAN: begin
                    if (r_scan_cnt == SCAN_LAST) begin
                        r_scan_cnt <= '0;
                        if (r_kpr_s == KPR_IDLE) begin
                            r_kpc <= next_col(r_kpc);
                        end else begin
                            r_pat     <= r_kpr_s;
                            r_deb_cnt <= '0;
                            r_state   <= DEBOUNCE;
                        end
                    end else begin
                        r_scan_cnt <= r_scan_cnt + 1'b1;
                    end
                end
                DEBOUNCE: begin
                    if (r_kpr_s == KPR_IDLE) begin
                        r_kpc      <= next_col(r_kpc);
                        r_scan_cnt <= '0;
                        r_state    <= SCAN;
                    end else if (r_kpr_s != r_pat) begin
                        r_pat     <= r_kpr_s;
                        r_deb_cnt <= '0;
                    end else if (r_deb_cnt == DEB_LAST) begin
                        r_deb_cnt  <= '0;
                        r_key_down <= 1'b1;
                        // Several rows low on one column is a ghost/multi-key: swallow it.
                        if (w_single) begin
                            r_key_code  <= w_code;
                            r_key_valid <= 1'b1;
                            r_state     <= EMIT;
                        end else begin
                            r_state <= RELEASE;
                        end
                    end else begin
                        r_deb_cnt <= r_deb_cnt + 1'b1;
                    end
                end
                EMIT: begin
                    if (key_ready) begin
                        r_key_valid <= 1'b0;
                        r_deb_cnt   <= '0;
                        r_state     <= RELEASE;
                    end
                end
                RELEASE: begin
                    if (r_kpr_s != KPR_IDLE) begin
                        r_deb_cnt <= '0;
                    end else if (r_deb_cnt == DEB_LAST) begin
                        r_deb_cnt  <= '0;
                        r_key_down <= 1'b0;
                        r_kpc      <= next_col(r_kpc);
                        r_scan_cnt <= '0;
                        r_state    <= SCAN;
                    end else begin
                        r_deb_cnt <= r_deb_cnt + 1'b1;
                    end
                end
                default: r_state <= SCAN;
            endcase
        end
    end

    assign kpc       = r_kpc;
    assign key_valid = r_key_valid;
    assign key_code  = r_key_code;
    assign key_down  = r_key_down;

endmodule
